// File: rtl/rr_priority_arbiter.sv
// N-way request arbiter with a registered one-hot grant and binary index.
// Supports fixed (MSB-first) or round-robin priority, grant locking and an optional hold watchdog.
module rr_priority_arbiter #(
  parameter  int IN_WIDTH  = 32,
  parameter  int MAX_HOLD  = 0,
  localparam int OUT_WIDTH = $clog2(IN_WIDTH),
  localparam int HOLD_W    = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mode,
  input  logic [IN_WIDTH-1:0]  in,
  input  logic                 release_i,
  output logic [IN_WIDTH-1:0]  grant,
  output logic [OUT_WIDTH-1:0] out,
  output logic                 valid,
  output logic                 timeout
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [OUT_WIDTH-1:0] PTR_TOP   = OUT_WIDTH'(IN_WIDTH - 1);
  localparam logic [HOLD_W-1:0]    HOLD_MAX  = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0]    HOLD_LAST = HOLD_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
  localparam logic [IN_WIDTH-1:0]  ONE_HOT0  = IN_WIDTH'(1);

  state_t               state;
  logic [OUT_WIDTH-1:0] rr_ptr;
  logic [HOLD_W-1:0]    hold_cnt;

  logic [IN_WIDTH-1:0]  rr_mask;
  logic [IN_WIDTH-1:0]  rr_masked;
  logic [OUT_WIDTH-1:0] winner;
  logic                 wd_hit;
  logic                 free_now;

  // Index of the highest set bit; 0 for an all-zero vector.
  function automatic logic [OUT_WIDTH-1:0] msb_index(input logic [IN_WIDTH-1:0] v);
    msb_index = '0;
    for (int i = 0; i < IN_WIDTH; i++) begin
      if (v[i]) msb_index = OUT_WIDTH'(i);
    end
  endfunction

  // Round-robin search rr_ptr downward with wrap: requests at or below the pointer
  // take precedence; if none, the plain MSB-first pick covers the wrapped part.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    rr_mask = '0;
    for (int i = 0; i < IN_WIDTH; i++) begin
      rr_mask[i] = (OUT_WIDTH'(i) <= rr_ptr);
    end
    rr_masked = in & rr_mask;
    if (mode && (rr_masked != '0)) winner = msb_index(rr_masked);
    else                           winner = msb_index(in);
  end

  assign wd_hit   = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
  assign free_now = release_i || !in[out] || wd_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      state    <= IDLE;
      rr_ptr   <= PTR_TOP;
      hold_cnt <= '0;
      grant    <= '0;
      out      <= '0;
      valid    <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (in != '0) begin
            state    <= BUSY;
            grant    <= ONE_HOT0 << winner;
            out      <= winner;
            valid    <= 1'b1;
            hold_cnt <= '0;
            // The served requester drops to lowest priority.
            rr_ptr   <= (winner == '0) ? PTR_TOP : winner - OUT_WIDTH'(1);
          end
        end
        BUSY: begin
          if (hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + HOLD_W'(1);
          if (free_now) begin
            state   <= IDLE;
            grant   <= '0;
            out     <= '0;
            valid   <= 1'b0;
            timeout <= wd_hit;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_priority_arbiter.sv
// Self-checking bench for rr_priority_arbiter: a reference model checked every cycle
// plus directed sequences with hand-computed grant indices.
module tb_rr_priority_arbiter;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         mode0, rel0, mode1, rel1;
  logic [N-1:0] in0, in1;
  logic [N-1:0] grant0, grant1;
  logic [2:0]   out0, out1;
  logic         valid0, valid1, timeout0, timeout1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rr_priority_arbiter #(.IN_WIDTH(N), .MAX_HOLD(0)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode0), .in(in0), .release_i(rel0),
    .grant(grant0), .out(out0), .valid(valid0), .timeout(timeout0)
  );

  rr_priority_arbiter #(.IN_WIDTH(N), .MAX_HOLD(4)) dut_wd (
    .clk(clk), .rst_n(rst_n), .mode(mode1), .in(in1), .release_i(rel1),
    .grant(grant1), .out(out1), .valid(valid1), .timeout(timeout1)
  );

  // Model: who holds the grant (-1 = nobody), how long, the rotating pointer, pending timeout.
  typedef struct packed {
    int   holder;
    int   age;
    int   ptr;
    logic to;
  } model_t;

  model_t m0, m1;

  function automatic model_t model_reset();
    model_t r;
    r.holder = -1;
    r.age    = 0;
    r.ptr    = N - 1;
    r.to     = 1'b0;
    return r;
  endfunction

  function automatic int pick(logic md, logic [N-1:0] req, int ptr);
    if (!md) begin
      for (int i = N - 1; i >= 0; i--) if (req[i]) return i;
    end else begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (ptr - k + N) % N;
        if (req[idx]) return idx;
      end
    end
    return -1;
  endfunction

  function automatic model_t step(model_t m, logic md, logic [N-1:0] req, logic rel, int max_hold);
    model_t n;
    logic   wd;
    n    = m;
    n.to = 1'b0;
    if (m.holder < 0) begin
      if (req != '0) begin
        n.holder = pick(md, req, m.ptr);
        n.age    = 0;
        n.ptr    = (n.holder + N - 1) % N;
      end
    end else begin
      wd = (max_hold != 0) && (m.age + 1 == max_hold);
      if (rel || !req[m.holder] || wd) begin
        n.holder = -1;
        n.to     = wd;
      end else begin
        n.age = m.age + 1;
      end
    end
    return n;
  endfunction

  initial begin
    m0 = model_reset();
    m1 = model_reset();
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0 <= model_reset();
      m1 <= model_reset();
    end else begin
      m0 <= step(m0, mode0, in0, rel0, 0);
      m1 <= step(m1, mode1, in1, rel1, 4);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare(input string tag, input model_t m, input logic [N-1:0] g,
                         input logic [2:0] o, input logic v, input logic t);
    logic [N-1:0] eg;
    eg = (m.holder >= 0) ? N'(1 << m.holder) : '0;
    check({tag, " grant"},   32'(g), 32'(eg));
    check({tag, " out"},     32'(o), (m.holder >= 0) ? 32'(m.holder) : 32'd0);
    check({tag, " valid"},   32'(v), 32'(m.holder >= 0));
    check({tag, " timeout"}, 32'(t), 32'(m.to));
  endtask

  always @(negedge clk) begin
    compare("model d0", m0, grant0, out0, valid0, timeout0);
    compare("model d1", m1, grant1, out1, valid1, timeout1);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  // At a negedge showing a grant: check it, release and present next_in, then check the bubble.
  task automatic grant_step(input string name, input int idx, input logic [N-1:0] next_in);
    check($sformatf("%s valid idx%0d", name, idx), 32'(valid0), 32'd1);
    check($sformatf("%s out idx%0d", name, idx),   32'(out0),   32'(idx));
    check($sformatf("%s grant idx%0d", name, idx), 32'(grant0), 32'(1) << idx);
    rel0 = 1'b1;
    in0  = next_in;
    tick();
    check($sformatf("%s bubble after idx%0d", name, idx), 32'(valid0), 32'd0);
    rel0 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global time limit: simulation did not finish");
    $fatal(1, "time limit");
  end

  int rr_order[9] = '{7, 6, 5, 4, 3, 2, 1, 0, 7};

  initial begin
    rst_n = 1'b0;
    mode0 = 1'b0; rel0 = 1'b0; in0 = '0;
    mode1 = 1'b0; rel1 = 1'b0; in1 = '0;
    tick();
    check("reset grant",   32'(grant0),   32'd0);
    check("reset out",     32'(out0),     32'd0);
    check("reset valid",   32'(valid0),   32'd0);
    check("reset timeout", 32'(timeout1), 32'd0);
    rst_n = 1'b1;
    tick();
    rel0 = 1'b1;
    tick();
    check("idle release ignored", 32'(valid0), 32'd0);
    rel0 = 1'b0;

    // Fixed priority: 5, then 2, then 1 as requests are dropped.
    in0 = 8'b0010_0110;
    tick(); grant_step("fixed", 5, 8'b0000_0110);
    tick(); grant_step("fixed", 2, 8'b0000_0010);
    tick(); grant_step("fixed", 1, 8'h00);

    // Round-robin with all requesting: 7 down to 0, then wrap to 7.
    reset_pulse();
    mode0 = 1'b1;
    in0   = 8'hFF;
    tick();
    for (int k = 0; k < 9; k++) begin
      grant_step("rr all", rr_order[k], 8'hFF);
      if (k < 8) tick();
    end
    in0 = '0;

    // Round-robin between the extremes: strict alternation 7,0,7,0.
    reset_pulse();
    in0 = 8'h81;
    tick();
    for (int k = 0; k < 4; k++) begin
      grant_step("rr alt", (k % 2 == 0) ? 7 : 0, 8'h81);
      if (k < 3) tick();
    end
    in0 = '0;

    // Dropped request frees the grant; re-raised 6 is now behind 5.
    reset_pulse();
    in0 = 8'b0110_0000;
    tick();
    check("drop first out", 32'(out0), 32'd6);
    mode0 = 1'b0;
    tick();
    check("mode change while busy out",   32'(out0),   32'd6);
    check("mode change while busy valid", 32'(valid0), 32'd1);
    mode0 = 1'b1;
    in0   = 8'b0010_0000;
    tick();
    check("drop frees grant", 32'(valid0), 32'd0);
    in0 = 8'b0110_0000;
    tick(); grant_step("drop regrant", 5, 8'b0110_0000);
    tick(); grant_step("drop regrant", 6, 8'h00);

    // Async reset while holding idx 4, then rr_ptr must be back at 7.
    reset_pulse();
    mode0 = 1'b0;
    in0   = 8'h10;
    tick();
    check("pre-reset out", 32'(out0), 32'd4);
    tick();
    check("pre-reset held", 32'(valid0), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async reset grant", 32'(grant0), 32'd0);
    check("async reset valid", 32'(valid0), 32'd0);
    check("async reset out",   32'(out0),   32'd0);
    tick();
    rst_n = 1'b1;
    mode0 = 1'b1;
    in0   = 8'h11;
    tick();
    check("post-reset rr out",   32'(out0),   32'd4);
    check("post-reset rr valid", 32'(valid0), 32'd1);
    in0  = '0;
    rel0 = 1'b1;
    tick();
    rel0 = 1'b0;

    // Watchdog (MAX_HOLD=4): four grant cycles, timeout pulse, re-grant.
    in1 = 8'h08;
    tick();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("wd hold valid c%0d", i), 32'(valid1),   32'd1);
      check($sformatf("wd hold out c%0d", i),   32'(out1),     32'd3);
      check($sformatf("wd hold to c%0d", i),    32'(timeout1), 32'd0);
      tick();
    end
    check("wd timeout pulse", 32'(timeout1), 32'd1);
    check("wd bubble valid",  32'(valid1),   32'd0);
    tick();
    check("wd regrant out",     32'(out1),     32'd3);
    check("wd regrant valid",   32'(valid1),   32'd1);
    check("wd timeout cleared", 32'(timeout1), 32'd0);
    tick();
    tick();
    tick();
    rel1 = 1'b1;
    tick();
    check("wd coincident release timeout", 32'(timeout1), 32'd1);
    check("wd coincident release valid",   32'(valid1),   32'd0);
    rel1 = 1'b0;
    in1  = '0;
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_priority_arbiter.md
Name: rr_priority_arbiter

Overview:
- Parametrised N-way request arbiter built around a one-hot priority-encode core.
- Extends the combinational encoder with several features:
  - registered one-hot grant plus binary index;
  - selectable fixed (MSB-first) or round-robin priority;
  - grant locking until release, with an optional hold-timeout watchdog.
- Sits in front of shared resources such as a bus master port or a memory bank, arbitrating among IN_WIDTH requesters.

Parameters:
- IN_WIDTH, 32, number of requesters (>=2).
- OUT_WIDTH, $clog2(IN_WIDTH), localparam; width of the binary grant index.
- MAX_HOLD, 0, maximum cycles a grant may be held before forced release; 0 disables the watchdog.
- HOLD_W, $clog2(MAX_HOLD+1) (min 1), localparam; hold counter width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- mode  input  1  0 = fixed priority (highest index wins), 1 = round-robin.
- in  input  IN_WIDTH  request vector; bit i = requester i.
- release_i  input  1  holder finished; frees the grant.
- grant  output  IN_WIDTH  registered one-hot grant; all-zero when idle.
- out  output  OUT_WIDTH  binary index of the granted bit; 0 when idle.
- valid  output  1  a grant is active.
- timeout  output  1  one-cycle pulse when the watchdog forces a release.

Behaviour:
- Reset (async assert, sync deassert at the next clk):
  - grant=0, out=0, valid=0, timeout=0;
  - state=IDLE, rr_ptr=IN_WIDTH-1, hold counter=0.
- States: IDLE, BUSY.
- IDLE:
  - If in==0: stay in IDLE, outputs stay zero.
  - Otherwise pick a winner combinationally from in.
  - On the next edge: grant=onehot(winner), out=winner, valid=1, state=BUSY, hold counter=0.
  - Latency from request sampled in IDLE to grant visible: 1 cycle.
- Fixed mode: the highest set index wins (bit IN_WIDTH-1 has top priority). Same function as the existing priority encoder.
- Round-robin mode:
  - Search order is rr_ptr, rr_ptr-1, ..., 0, IN_WIDTH-1, ... (downward, wrapping).
  - The first set bit wins.
- rr_ptr is updated on every grant issue, in both modes: rr_ptr = (winner-1) mod IN_WIDTH. The just-served requester therefore becomes lowest priority. Winner 0 wraps rr_ptr to IN_WIDTH-1.
- mode is sampled only in IDLE. A change while BUSY has no effect on the current grant.
- BUSY:
  - grant, out and valid hold constant.
  - Hold counter increments each cycle, saturating at MAX_HOLD.
  - Any of the following frees the grant on this edge:
    - release_i=1;
    - in[out]=0 (holder dropped its request);
    - MAX_HOLD!=0 and counter==MAX_HOLD-1 (watchdog).
  - When freed: next cycle grant=0, out=0, valid=0, state=IDLE. This is one mandatory idle bubble between grants.
  - A watchdog release additionally produces timeout=1 for exactly that following cycle. If release_i or a dropped request coincides with the watchdog, timeout still pulses.
- Changes to non-granted bits of in while BUSY are ignored. They are re-evaluated in the next IDLE cycle.
- release_i in IDLE is ignored.
- Invariants: grant is always zero or one-hot; when valid=1, grant[out]=1.
- Reset mid-BUSY drops the grant immediately (asynchronous) and returns rr_ptr to IN_WIDTH-1.

Test Plan:
- IN_WIDTH=8, mode=0, in=8'b0010_0110, release_i pulsed each time valid=1 -> grant index 5. The bench drops bit 5 after its grant, then bit 2, so each later grant sees only the remaining requests. Grant sequence 5, 2, 1, each with a 1-cycle bubble between grants.
- mode=1, in=8'hFF held, release_i pulsed on each grant cycle -> grant order 7,6,5,...,0,7; rr_ptr wraps 0->7; valid toggles 1,0,1,0.
- mode=1, in=8'b1000_0001 held, release each grant -> strict alternation 7,0,7,0. This proves no starvation of bit 0.
- MAX_HOLD=4, in[3] held alone, release_i=0 -> grant idx 3 valid for exactly 4 cycles. Then timeout=1 with valid=0 for one cycle, then a re-grant to 3.
- Grant to idx 6; bench drops in[6] without release_i -> valid=0 next cycle. If in[6] is re-raised in the same IDLE cycle, a re-grant follows under the current mode (round-robin: idx 6 is now last).
- rst_n asserted low while BUSY with grant idx 4 -> grant=0, valid=0 immediately without a clock edge. After deassert, mode=1, in=8'h11 -> first grant is idx 4, showing rr_ptr was reset to 7.
